mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 33 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response bundle between the fetch/data ports, the arbiter and the RAM.
// master = requester + RAM model side, slave = arbiter side.
interface mem_arbiter_if;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        halt;
  logic        halted;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        ramerr;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    output iwait, iload, dwait, dload, halted, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramstate,
    input  iwait, iload, dwait, dload, halted, ramREN, ramWEN, ramaddr, ramstore, ramerr
  );
endinterface

// File: rtl/mem_arbiter.sv
// Instruction/data arbiter onto a single RAM port; data wins unless the
// ARB_STARVE_GUARD_EN macro enables the instruction starvation guard.
//
// state  | meaning
// IDLE   | no grant; decide next owner
// IGNT   | instruction fetch owns the RAM
// DGNT   | data access owns the RAM
// HALTED | closed after halt; only RST leaves
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] IGNT   = 2'd1;
  localparam logic [1:0] DGNT   = 2'd2;
  localparam logic [1:0] HALTED = 2'd3;

  localparam logic [1:0] RAM_FREE   = 2'd0;
  localparam logic [1:0] RAM_BUSY   = 2'd1;
  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  logic [1:0]  state, state_nxt, cur;
  logic        i_req, d_req, ram_done, ram_idle;
  logic        i_done, d_done, starve_force;
  logic        ram_ren, ram_wen, i_wait, d_wait;
  logic [31:0] ram_addr, ram_store;
  logic        ramerr_q;

  // Reset overrides the registered state so outputs look like IDLE while RST is high.
  assign cur      = RST ? IDLE : state;
  assign i_req    = bus.iREN;
  assign d_req    = bus.dREN | bus.dWEN;
  assign ram_done = (bus.ramstate == RAM_ACCESS) || (bus.ramstate == RAM_ERROR);
  assign ram_idle = (bus.ramstate == RAM_FREE) || (bus.ramstate == RAM_BUSY);

  always_comb begin
    state_nxt = cur;
    ram_ren   = 1'b0;
    ram_wen   = 1'b0;
    ram_addr  = '0;
    ram_store = '0;
    i_wait    = i_req;
    d_wait    = d_req;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (cur)
      IDLE: begin
        if (bus.halt)                 state_nxt = HALTED;
        else if (starve_force && i_req) state_nxt = IGNT;
        else if (d_req)               state_nxt = DGNT;
        else if (i_req)               state_nxt = IGNT;
      end
      IGNT: begin
        if (!i_req) begin
          state_nxt = IDLE;
        end else begin
          ram_ren  = 1'b1;
          ram_addr = bus.iaddr;
          if (ram_done) begin
            i_wait    = 1'b0;
            i_done    = 1'b1;
            state_nxt = bus.halt ? HALTED : IDLE;
          end
        end
      end
      DGNT: begin
        if (!d_req) begin
          state_nxt = IDLE;
        end else begin
          ram_wen   = bus.dWEN;
          ram_ren   = bus.dREN & ~bus.dWEN;
          ram_addr  = bus.daddr;
          ram_store = bus.dstore;
          if (ram_done) begin
            d_wait    = 1'b0;
            d_done    = 1'b1;
            state_nxt = bus.halt ? HALTED : IDLE;
          end
        end
      end
      default: state_nxt = HALTED;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      ramerr_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      ramerr_q <= (i_done | d_done) & (bus.ramstate == RAM_ERROR);
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  logic [CW-1:0] starve_cnt;

  // Only data completions that left a fetch waiting count toward starvation.
  always_ff @(posedge CLK) begin
    if (RST)
      starve_cnt <= '0;
    else if (i_done || (d_done && !i_req))
      starve_cnt <= '0;
    else if (d_done && starve_cnt != LIMIT)
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign starve_force = (starve_cnt == LIMIT);
`else
  logic unused_starve;
  assign unused_starve = (STARVE_LIMIT == 0);
  assign starve_force  = 1'b0;
`endif

  logic unused_ramstate;
  assign unused_ramstate = ram_idle;

  assign bus.ramREN   = ram_ren;
  assign bus.ramWEN   = ram_wen;
  assign bus.ramaddr  = ram_addr;
  assign bus.ramstore = ram_store;
  assign bus.iwait    = i_wait;
  assign bus.dwait    = d_wait;
  assign bus.iload    = bus.ramload;
  assign bus.dload    = bus.ramload;
  assign bus.halted   = (cur == HALTED);
  assign bus.ramerr   = ramerr_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: fetch, priority, wait states, errors,
// abort, reset, starvation guard sequence and halt.
module tb_mem_arbiter;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_arbiter_if bus ();
  mem_arbiter #(.STARVE_LIMIT(4)) dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.iREN = 0; bus.iaddr = 0; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.halt = 0; bus.ramload = 0; bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    RST = 1;
    clear_inputs();
    tick(); tick();
    @(negedge CLK);
    chk("rst_halted", {31'd0, bus.halted}, 0);
    chk("rst_ramREN", {31'd0, bus.ramREN}, 0);
    chk("rst_ramWEN", {31'd0, bus.ramWEN}, 0);
    chk("rst_iwait", {31'd0, bus.iwait}, 0);
    chk("rst_ramerr", {31'd0, bus.ramerr}, 0);
    bus.iREN = 1;
    #1;
    chk("rst_iwait_req", {31'd0, bus.iwait}, 1);
    chk("rst_ramREN_req", {31'd0, bus.ramREN}, 0);
    tick();
    chk("rst_hold_ramREN", {31'd0, bus.ramREN}, 0);
    bus.iREN = 0;
    RST = 0;
  endtask

  task automatic test_ifetch();
    bus.iREN = 1; bus.iaddr = 32'h40; bus.ramstate = ACCESS; bus.ramload = 32'h3C010001;
    @(negedge CLK);
    chk("if_c1_iwait", {31'd0, bus.iwait}, 1);
    chk("if_c1_ramREN", {31'd0, bus.ramREN}, 0);
    tick();
    @(negedge CLK);
    chk("if_c2_ramREN", {31'd0, bus.ramREN}, 1);
    chk("if_c2_ramWEN", {31'd0, bus.ramWEN}, 0);
    chk("if_c2_ramaddr", bus.ramaddr, 32'h40);
    chk("if_c2_iwait", {31'd0, bus.iwait}, 0);
    chk("if_c2_iload", bus.iload, 32'h3C010001);
    tick();
    bus.iREN = 0; bus.ramstate = FREE;
    @(negedge CLK);
    chk("if_c3_ramREN", {31'd0, bus.ramREN}, 0);
    chk("if_c3_iwait", {31'd0, bus.iwait}, 0);
  endtask

  task automatic test_priority();
    bus.iREN = 1; bus.iaddr = 32'h44;
    bus.dWEN = 1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF; bus.ramstate = BUSY;
    @(negedge CLK);
    chk("pr_idle_iwait", {31'd0, bus.iwait}, 1);
    chk("pr_idle_dwait", {31'd0, bus.dwait}, 1);
    tick();
    @(negedge CLK);
    chk("pr_d_ramWEN", {31'd0, bus.ramWEN}, 1);
    chk("pr_d_ramREN", {31'd0, bus.ramREN}, 0);
    chk("pr_d_ramaddr", bus.ramaddr, 32'h80);
    chk("pr_d_ramstore", bus.ramstore, 32'hDEADBEEF);
    chk("pr_d_busy_dwait", {31'd0, bus.dwait}, 1);
    chk("pr_d_busy_iwait", {31'd0, bus.iwait}, 1);
    bus.ramstate = ACCESS;
    #1;
    chk("pr_d_acc_dwait", {31'd0, bus.dwait}, 0);
    chk("pr_d_acc_iwait", {31'd0, bus.iwait}, 1);
    tick();
    bus.dWEN = 0;
    @(negedge CLK);
    chk("pr_idle2_ramREN", {31'd0, bus.ramREN}, 0);
    chk("pr_idle2_iwait", {31'd0, bus.iwait}, 1);
    tick();
    @(negedge CLK);
    chk("pr_i_ramREN", {31'd0, bus.ramREN}, 1);
    chk("pr_i_ramaddr", bus.ramaddr, 32'h44);
    chk("pr_i_iwait", {31'd0, bus.iwait}, 0);
    tick();
    clear_inputs();
  endtask

  task automatic test_busy();
    bus.dREN = 1; bus.daddr = 32'h100; bus.ramstate = BUSY; bus.ramload = 32'h1234;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("busy_dwait_%0d", c), {31'd0, bus.dwait}, 1);
      if (c > 0) begin
        chk($sformatf("busy_ramaddr_%0d", c), bus.ramaddr, 32'h100);
        chk($sformatf("busy_ramREN_%0d", c), {31'd0, bus.ramREN}, 1);
      end
      tick();
    end
    bus.ramstate = ACCESS;
    @(negedge CLK);
    chk("busy_done_dwait", {31'd0, bus.dwait}, 0);
    chk("busy_done_dload", bus.dload, 32'h1234);
    chk("busy_done_ramaddr", bus.ramaddr, 32'h100);
    tick();
    clear_inputs();
  endtask

  task automatic test_error();
    bus.iREN = 1; bus.iaddr = 32'h60; bus.ramstate = ERROR;
    @(negedge CLK);
    chk("err_idle_ramerr", {31'd0, bus.ramerr}, 0);
    tick();
    @(negedge CLK);
    chk("err_grant_iwait", {31'd0, bus.iwait}, 0);
    chk("err_grant_ramerr", {31'd0, bus.ramerr}, 0);
    tick();
    clear_inputs();
    @(negedge CLK);
    chk("err_pulse", {31'd0, bus.ramerr}, 1);
    tick();
    @(negedge CLK);
    chk("err_pulse_end", {31'd0, bus.ramerr}, 0);
  endtask

  task automatic test_abort();
    bus.dREN = 1; bus.daddr = 32'h180; bus.ramstate = BUSY;
    tick();
    @(negedge CLK);
    chk("ab_grant_ramREN", {31'd0, bus.ramREN}, 1);
    bus.dREN = 0;
    #1;
    chk("ab_drop_ramREN", {31'd0, bus.ramREN}, 0);
    chk("ab_drop_ramaddr", bus.ramaddr, 0);
    chk("ab_drop_dwait", {31'd0, bus.dwait}, 0);
    tick();
    bus.iREN = 1; bus.iaddr = 32'h1C0; bus.ramstate = ACCESS;
    tick();
    @(negedge CLK);
    chk("ab_next_igrant", {31'd0, bus.ramREN}, 1);
    chk("ab_next_iaddr", bus.ramaddr, 32'h1C0);
    tick();
    clear_inputs();
  endtask

  task automatic test_rst_mid();
    bus.dWEN = 1; bus.daddr = 32'h240; bus.dstore = 32'h55; bus.ramstate = BUSY;
    tick();
    @(negedge CLK);
    chk("rm_grant_ramWEN", {31'd0, bus.ramWEN}, 1);
    RST = 1;
    #1;
    chk("rm_rst_comb_ramWEN", {31'd0, bus.ramWEN}, 0);
    tick();
    RST = 0;
    @(negedge CLK);
    chk("rm_after_ramWEN", {31'd0, bus.ramWEN}, 0);
    chk("rm_after_ramaddr", bus.ramaddr, 0);
    chk("rm_after_dwait", {31'd0, bus.dwait}, 1);
    tick();
    @(negedge CLK);
    chk("rm_regrant_ramWEN", {31'd0, bus.ramWEN}, 1);
    clear_inputs();
    tick();
  endtask

  task automatic test_starve();
    string exp_seq;
    byte   got [10];
    int    ng = 0;
`ifdef ARB_STARVE_GUARD_EN
    exp_seq = "DDDDIDDDDI";
`else
    exp_seq = "DDDDDDDDDD";
`endif
    bus.iREN = 1; bus.iaddr = 32'h200; bus.dREN = 1; bus.daddr = 32'h300; bus.ramstate = ACCESS;
    for (int c = 0; c < 60 && ng < 10; c++) begin
      @(negedge CLK);
      if (bus.ramREN) begin
        got[ng] = (bus.ramaddr == 32'h200) ? "I" : "D";
        ng++;
      end
      tick();
    end
    chk("starve_grant_count", ng, 10);
    for (int k = 0; k < ng; k++)
      chk($sformatf("starve_grant_%0d", k), {24'd0, got[k]}, {24'd0, exp_seq[k]});
    clear_inputs();
    tick();
  endtask

  task automatic test_halt();
    bus.dREN = 1; bus.daddr = 32'h500; bus.ramstate = BUSY; bus.ramload = 32'hA5;
    @(negedge CLK);
    chk("h_idle_dwait", {31'd0, bus.dwait}, 1);
    tick();
    bus.halt = 1;
    @(negedge CLK);
    chk("h_busy_dwait", {31'd0, bus.dwait}, 1);
    chk("h_busy_halted", {31'd0, bus.halted}, 0);
    chk("h_busy_ramREN", {31'd0, bus.ramREN}, 1);
    bus.ramstate = ACCESS;
    #1;
    chk("h_done_dwait", {31'd0, bus.dwait}, 0);
    chk("h_done_dload", bus.dload, 32'hA5);
    tick();
    bus.dREN = 0; bus.halt = 0; bus.iREN = 1; bus.iaddr = 32'h600;
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk($sformatf("h_halted_%0d", c), {31'd0, bus.halted}, 1);
      chk($sformatf("h_iwait_%0d", c), {31'd0, bus.iwait}, 1);
      chk($sformatf("h_ramREN_%0d", c), {31'd0, bus.ramREN}, 0);
      tick();
    end
    RST = 1;
    tick();
    RST = 0; bus.iREN = 0;
    @(negedge CLK);
    chk("h_after_rst_halted", {31'd0, bus.halted}, 0);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_ifetch();
    test_priority();
    test_busy();
    test_error();
    test_abort();
    test_rst_mid();
    test_starve();
    test_halt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
